gcbp_frame_sched: RTL
=====================

Name: gcbp_frame_sched

Overview:
Frame-slot scheduler for the GCBP triple-buffered BRAM array.
- Owns the next/curr/prev slot indices (0..2) that steer GCBP writes and motion-estimation (ME) reads.
- Rotates slots on frame boundaries, gates writes until the first frame start, and qualifies frames by line count.
- Hands completed curr/prev pairs to the ME engine with a start/done handshake.
- Drops frames when ME is still busy, with a timeout watchdog on ME.

Parameters:
MIN_LINES, 480, minimum i_new_line pulses for a closed frame to count as complete
LINE_W, 10, width of internal line counter (saturates at all-ones)
DROP_W, 8, width of o_drop_cnt
ME_TIMEOUT, 2000000, cycles in ME_BUSY before forced abort

Ports:
i_clk  in  1  clock, rising edge
i_resetn  in  1  asynchronous active-low reset
i_new_frame  in  1  single-cycle frame-start pulse
i_new_line  in  1  single-cycle line-start pulse
i_me_done  in  1  single-cycle pulse from ME: current pair consumed
o_next_frame_loc  out  2  slot GCBP is writing
o_curr_frame_loc  out  2  most recent completed frame slot
o_prev_frame_loc  out  2  frame before curr
o_write_enable  out  1  GCBP BRAM writes permitted
o_me_start  out  1  single-cycle pulse: curr/prev pair ready
o_me_busy  out  1  ME owns curr/prev slots
o_frame_dropped  out  1  single-cycle pulse: complete frame discarded because ME busy
o_frame_short  out  1  single-cycle pulse: closed frame had < MIN_LINES lines
o_me_timeout  out  1  single-cycle pulse: ME watchdog fired
o_drop_cnt  out  DROP_W  count of dropped plus short frames, saturating
o_valid_frames  out  2  completed frames held (0, 1, 2), saturating at 2

Behaviour:
- Reset (async, all registers):
  - next=0, curr=1, prev=2; state=WAIT_FIRST.
  - All pulses, o_write_enable, o_me_busy, o_drop_cnt, o_valid_frames, line counter and watchdog = 0.
- States:
  - WAIT_FIRST: writes off.
  - CAPTURE: writes on, ME idle.
  - ME_BUSY: writes on, ME running.
- All outputs are registered. Response to a sampled input pulse appears the following cycle (1-cycle latency).
- Line counter:
  - Increments on i_new_line and saturates.
  - On an i_new_frame cycle it loads 1 if i_new_line is also high, else 0.
- WAIT_FIRST + i_new_frame: go to CAPTURE, set o_write_enable=1. No frame is closed, so no rotation.
- CAPTURE + i_new_frame (closes a frame):
  - If lines < MIN_LINES: pulse o_frame_short, increment o_drop_cnt, no rotation. next is reused and overwritten.
  - Else rotate: prev<=curr, curr<=next, next<=old prev; o_valid_frames<=min(v+1, 2).
  - If the post-rotate value is 2: pulse o_me_start, set o_me_busy=1, go to ME_BUSY, clear watchdog.
- ME_BUSY:
  - Watchdog increments each cycle.
  - i_me_done: o_me_busy=0, go to CAPTURE.
  - Complete frame closed while busy: no rotation (curr/prev locked), next overwritten, pulse o_frame_dropped, increment o_drop_cnt.
  - Short frame while busy: pulse o_frame_short only, increment o_drop_cnt.
  - Watchdog reaches ME_TIMEOUT-1: pulse o_me_timeout, clear o_me_busy, go to CAPTURE.
- i_me_done and i_new_frame in the same ME_BUSY cycle: done wins. The frame is handled as in CAPTURE (rotate, immediate o_me_start if complete), with no drop.
- i_me_done outside ME_BUSY: ignored.
- Timeout and i_me_done in the same cycle: treat as done, no timeout pulse.
- Invariant: the three slot indices are always a permutation of {0, 1, 2}.
- o_drop_cnt holds at all-ones once saturated.
- Reset asserted mid-frame or mid-ME: immediate return to the reset values; the next frame start behaves as the first.

Test Plan:
- Reset, then one i_new_frame: locs stay 0/1/2, o_write_enable=1 the next cycle, no o_me_start, o_valid_frames=0.
- Two frames of 480 lines each followed by i_new_frame: after frame 1, locs 2/0/1 and valid=1. After frame 2, locs 1/2/0, valid=2, o_me_start pulses exactly 1 cycle, o_me_busy=1.
- ME busy and a third 480-line frame closes: locs unchanged at 1/2/0, o_frame_dropped 1-cycle pulse, o_drop_cnt=1. Then i_me_done -> o_me_busy=0; next complete frame rotates to 0/1/2 with o_me_start.
- Frame closed after 100 lines (MIN_LINES=480): o_frame_short pulse, o_drop_cnt increments, locs and o_valid_frames unchanged.
- i_me_done coincident with i_new_frame after 480 lines: no drop. Rotation and o_me_start occur on the next cycle, o_me_busy stays 1.
- ME_TIMEOUT=16, no i_me_done: o_me_timeout pulses 16 cycles after o_me_start, o_me_busy=0. Reset asserted mid-ME: all outputs immediately return to reset values.

Source files
------------

// File: rtl/gcbp_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : gcbp_frame_sched
// Description : Frame-slot scheduler for the GCBP triple-buffered BRAM array.
//               Rotates next/curr/prev slot indices on qualified frame
//               boundaries and hands curr/prev pairs to the ME engine with a
//               start/done handshake guarded by a timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module gcbp_frame_sched #(
  parameter int unsigned MIN_LINES  = 480,
  parameter int unsigned LINE_W     = 10,
  parameter int unsigned DROP_W     = 8,
  parameter int unsigned ME_TIMEOUT = 2000000
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_new_frame,
  input  logic              i_new_line,
  input  logic              i_me_done,
  output logic [1:0]        o_next_frame_loc,
  output logic [1:0]        o_curr_frame_loc,
  output logic [1:0]        o_prev_frame_loc,
  output logic              o_write_enable,
  output logic              o_me_start,
  output logic              o_me_busy,
  output logic              o_frame_dropped,
  output logic              o_frame_short,
  output logic              o_me_timeout,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic [1:0]        o_valid_frames
);

  // Watchdog only needs to reach ME_TIMEOUT-1
  localparam int unsigned c_wd_w = (ME_TIMEOUT > 2) ? $clog2(ME_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    CAPTURE    = 2'd1,
    ME_BUSY    = 2'd2
  } state_t;

  state_t              r_state;
  logic [LINE_W-1:0]   r_line_cnt;
  logic [c_wd_w-1:0]   r_wd;

  logic                w_lines_ok;
  logic                w_close;
  logic                w_accept;
  logic                w_drop_max;
  logic                w_wd_expired;
  logic [1:0]          w_valid_inc;

  assign w_lines_ok   = (32'(r_line_cnt) >= MIN_LINES);
  // A frame is closed by any frame start once capture has begun
  assign w_close      = i_new_frame && ((r_state == CAPTURE) || (r_state == ME_BUSY));
  // A complete frame may rotate unless ME still owns the slots (done wins)
  assign w_accept     = (r_state == CAPTURE) || ((r_state == ME_BUSY) && i_me_done);
  assign w_drop_max   = &o_drop_cnt;
  assign w_wd_expired = (r_wd == c_wd_w'(ME_TIMEOUT - 1));
  assign w_valid_inc  = (o_valid_frames == 2'd2) ? 2'd2 : o_valid_frames + 2'd1;

  // Line counter: restarts on each frame start, saturates at all-ones
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_line_cnt <= '0;
    end else if (i_new_frame) begin
      r_line_cnt <= LINE_W'(i_new_line);
    end else if (i_new_line && !(&r_line_cnt)) begin
      r_line_cnt <= r_line_cnt + LINE_W'(1);
    end
  end

  // Scheduler FSM: slot rotation, ME handshake, drop accounting and watchdog
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state          <= WAIT_FIRST;
      r_wd             <= '0;
      o_next_frame_loc <= 2'd0;
      o_curr_frame_loc <= 2'd1;
      o_prev_frame_loc <= 2'd2;
      o_write_enable   <= 1'b0;
      o_me_start       <= 1'b0;
      o_me_busy        <= 1'b0;
      o_frame_dropped  <= 1'b0;
      o_frame_short    <= 1'b0;
      o_me_timeout     <= 1'b0;
      o_drop_cnt       <= '0;
      o_valid_frames   <= 2'd0;
    end else begin
      o_me_start      <= 1'b0;
      o_frame_dropped <= 1'b0;
      o_frame_short   <= 1'b0;
      o_me_timeout    <= 1'b0;

      case (r_state)
        WAIT_FIRST: begin
          if (i_new_frame) begin
            r_state        <= CAPTURE;
            o_write_enable <= 1'b1;
          end
        end
        CAPTURE: begin
        end
        ME_BUSY: begin
          r_wd <= r_wd + c_wd_w'(1);
          if (i_me_done) begin
            o_me_busy <= 1'b0;
            r_state   <= CAPTURE;
          end else if (w_wd_expired) begin
            o_me_timeout <= 1'b1;
            o_me_busy    <= 1'b0;
            r_state      <= CAPTURE;
          end
        end
        default: begin
          r_state        <= WAIT_FIRST;
          o_write_enable <= 1'b0;
        end
      endcase

      // Frame close handling; a new ME start overrides the done/timeout exit
      if (w_close) begin
        if (!w_lines_ok) begin
          o_frame_short <= 1'b1;
          if (!w_drop_max) o_drop_cnt <= o_drop_cnt + DROP_W'(1);
        end else if (w_accept) begin
          o_prev_frame_loc <= o_curr_frame_loc;
          o_curr_frame_loc <= o_next_frame_loc;
          o_next_frame_loc <= o_prev_frame_loc;
          o_valid_frames   <= w_valid_inc;
          if (w_valid_inc == 2'd2) begin
            o_me_start <= 1'b1;
            o_me_busy  <= 1'b1;
            r_state    <= ME_BUSY;
            r_wd       <= '0;
          end
        end else begin
          o_frame_dropped <= 1'b1;
          if (!w_drop_max) o_drop_cnt <= o_drop_cnt + DROP_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
